// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction memory, decode hand-off, execute redirect and BHT training.
interface fetch_unit_if;
  logic [31:0] instr;
  logic        i_ready;
  logic [47:0] pc;
  logic [31:0] if_instr;
  logic [47:0] if_pc;
  logic        if_pred_taken;
  logic        if_valid;
  logic        id_stall;
  logic        redirect;
  logic [47:0] redirect_pc;
  logic        bht_update;
  logic [47:0] bht_update_pc;
  logic        bht_update_taken;

  modport master (
    input  instr, i_ready, id_stall, redirect, redirect_pc,
           bht_update, bht_update_pc, bht_update_taken,
    output pc, if_instr, if_pc, if_pred_taken, if_valid
  );
  modport slave (
    output instr, i_ready, id_stall, redirect, redirect_pc,
           bht_update, bht_update_pc, bht_update_taken,
    input  pc, if_instr, if_pc, if_pred_taken, if_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, one-entry fetch register and
// zero-bubble next-PC prediction (bimodal BHT, JAL target, return address stack).
module fetch_unit #(
  parameter int          bht_size = 256,
  parameter int          ras_size = 8,
  parameter logic [47:0] reset_pc = 48'h0
) (
  input  logic          clk,
  input  logic          n_reset,
  fetch_unit_if.master  bus
);
  localparam int BW = $clog2(bht_size);
  localparam int RW = $clog2(ras_size);
  localparam logic [RW:0] RAS_FULL = (RW+1)'(ras_size);

  typedef logic [47:0] addr_t;

  addr_t       pc_q, if_pc_q, pc_plus4, imm_b, imm_j, next_pc, ras_top;
  logic [31:0] if_instr_q;
  logic        if_valid_q, if_pred_q;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1;
  logic        rd_link, rs1_link;
  logic        pred_taken, push, pop, accept;

  logic [1:0]    bht [bht_size];
  logic [BW-1:0] lookup_idx, update_idx;

  addr_t       ras_mem [ras_size];
  logic [RW-1:0] ras_ptr;   // next free slot; top entry sits at ras_ptr-1
  logic [RW:0]   ras_cnt;

  logic unused_bits;
  assign unused_bits = ^{bus.bht_update_pc[47:BW+2], bus.bht_update_pc[1:0]};

  assign opcode   = bus.instr[6:0];
  assign rd       = bus.instr[11:7];
  assign rs1      = bus.instr[19:15];
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign imm_b    = {{35{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                     bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign imm_j    = {{27{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                     bus.instr[20], bus.instr[30:21], 1'b0};
  assign pc_plus4 = pc_q + 48'd4;

  assign lookup_idx = pc_q[BW+1:2];
  assign update_idx = bus.bht_update_pc[BW+1:2];
  assign ras_top    = ras_mem[ras_ptr - 1'b1];
  assign accept     = bus.i_ready && !bus.id_stall && !bus.redirect;

  always_comb begin
    next_pc    = pc_plus4;
    pred_taken = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (opcode)
      7'b1100011: if (bht[lookup_idx][1]) begin
        next_pc    = pc_q + imm_b;
        pred_taken = 1'b1;
      end
      7'b1101111: begin
        next_pc    = pc_q + imm_j;
        pred_taken = 1'b1;
        push       = rd_link;
      end
      7'b1100111: begin
        // Returns (rd=x0) and coroutine swaps (rd link) consume the top entry;
        // with an empty stack a link-writing JALR still pushes its return address.
        push = rd_link;
        if (rs1_link && (rd == 5'd0 || rd_link) && ras_cnt != '0) begin
          pop        = 1'b1;
          next_pc    = ras_top;
          pred_taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc_q       <= reset_pc;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_pred_q  <= 1'b0;
      if_valid_q <= 1'b0;
    end else if (bus.redirect) begin
      pc_q       <= bus.redirect_pc;
      if_valid_q <= 1'b0;
      if_pred_q  <= 1'b0;
    end else if (!bus.id_stall) begin
      if (bus.i_ready) begin
        pc_q       <= next_pc;
        if_instr_q <= bus.instr;
        if_pc_q    <= pc_q;
        if_pred_q  <= pred_taken;
        if_valid_q <= 1'b1;
      end else begin
        if_valid_q <= 1'b0;
      end
    end
  end

  // Pop+push rewrites the top in place, so pointer and count stay put.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (accept) begin
      if (pop && !push) begin
        ras_ptr <= ras_ptr - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
      end else if (push && !pop) begin
        ras_ptr <= ras_ptr + 1'b1;
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && push) ras_mem[pop ? ras_ptr - 1'b1 : ras_ptr] <= pc_plus4;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < bht_size; i++) bht[i] <= 2'b01;
    end else if (bus.bht_update) begin
      if (bus.bht_update_taken && bht[update_idx] != 2'b11)
        bht[update_idx] <= bht[update_idx] + 2'b01;
      else if (!bus.bht_update_taken && bht[update_idx] != 2'b00)
        bht[update_idx] <= bht[update_idx] - 2'b01;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.if_instr      = if_instr_q;
  assign bus.if_pc         = if_pc_q;
  assign bus.if_pred_taken = if_pred_q;
  assign bus.if_valid      = if_valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard on the fetch register plus
// per-scenario next-PC checks.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_unit #(.bht_size(256), .ras_size(8), .reset_pc(48'h0)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus.master));

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL1  = 32'h1000_00EF; // jal x1, +0x100
  localparam logic [31:0] RET   = 32'h0000_8067; // jalr x0, 0(x1)
  localparam logic [31:0] CORO  = 32'h0000_80E7; // jalr x1, 0(x1)
  localparam logic [31:0] JALR2 = 32'h0001_0067; // jalr x0, 0(x2)
  localparam logic [31:0] BEQ   = 32'h0200_0063; // beq x0, x0, +0x20

  typedef struct packed { logic [47:0] pc; logic [31:0] ins; logic tk; } exp_t;
  exp_t sbq[$];
  int total = 0, passed = 0;

  // Scoreboard: every accepted fetch must appear in the fetch register next edge.
  always @(posedge clk) begin
    logic acc;
    exp_t e;
    acc = n_reset && bus.i_ready && !bus.id_stall && !bus.redirect;
    #1;
    if (acc) begin
      total++;
      if (sbq.size() == 0) $display("FAIL sb_empty: unexpected accept, if_pc=%h", bus.if_pc);
      else begin
        e = sbq.pop_front();
        if ({bus.if_valid, bus.if_pc, bus.if_instr, bus.if_pred_taken} !== {1'b1, e.pc, e.ins, e.tk})
          $display("FAIL sb_out: got v=%b pc=%h ins=%h tk=%b, expected v=1 pc=%h ins=%h tk=%b",
                   bus.if_valid, bus.if_pc, bus.if_instr, bus.if_pred_taken, e.pc, e.ins, e.tk);
        else passed++;
      end
    end
  end

  task automatic go(input logic [31:0] ins, input logic [47:0] cur, input logic tk);
    bus.instr = ins; bus.i_ready = 1'b1; bus.id_stall = 1'b0; bus.redirect = 1'b0;
    sbq.push_back({cur, ins, tk});
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic jump(input logic [47:0] a);
    bus.redirect = 1'b1; bus.redirect_pc = a; bus.i_ready = 1'b0; bus.id_stall = 1'b0;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
  endtask

  task automatic train(input logic [47:0] a, input logic tk, input int n);
    repeat (n) begin
      bus.bht_update = 1'b1; bus.bht_update_pc = a; bus.bht_update_taken = tk;
      @(posedge clk); #1;
    end
    bus.bht_update = 1'b0;
  endtask

  task automatic test_reset;
    bus.instr = '0; bus.i_ready = 0; bus.id_stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    bus.bht_update = 0; bus.bht_update_pc = '0; bus.bht_update_taken = 0;
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.pc !== 48'h0) $display("FAIL rst_pc: got %h expected 0", bus.pc); else passed++;
    total++; if (bus.if_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.if_valid); else passed++;
    total++; if (bus.if_pred_taken !== 1'b0) $display("FAIL rst_pred: got %b expected 0", bus.if_pred_taken); else passed++;
    total++; if ({bus.if_pc, bus.if_instr} !== 80'h0) $display("FAIL rst_if: got pc=%h ins=%h expected 0", bus.if_pc, bus.if_instr); else passed++;
    @(negedge clk) n_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 4; i++) begin
      go(NOP, 48'(4*i), 1'b0);
      total++; if (bus.pc !== 48'(4*(i+1))) $display("FAIL seq_pc%0d: got %h expected %h", i, bus.pc, 48'(4*(i+1))); else passed++;
    end
  endtask

  task automatic test_jal_ret;
    jump(48'h40);
    total++; if (bus.pc !== 48'h40) $display("FAIL redir_pc: got %h expected 40", bus.pc); else passed++;
    go(JAL1, 48'h40, 1'b1);
    total++; if (bus.pc !== 48'h140) $display("FAIL jal_pc: got %h expected 140", bus.pc); else passed++;
    go(RET, 48'h140, 1'b1);
    total++; if (bus.pc !== 48'h44) $display("FAIL ret_pc: got %h expected 44", bus.pc); else passed++;
    go(RET, 48'h44, 1'b0);
    total++; if (bus.pc !== 48'h48) $display("FAIL ret_empty: got %h expected 48", bus.pc); else passed++;
    go(JALR2, 48'h48, 1'b0);
    total++; if (bus.pc !== 48'h4C) $display("FAIL jalr_other: got %h expected 4c", bus.pc); else passed++;
    jump(48'h500);
    go(JAL1, 48'h500, 1'b1);
    go(CORO, 48'h600, 1'b1);
    total++; if (bus.pc !== 48'h504) $display("FAIL coro_pc: got %h expected 504", bus.pc); else passed++;
    go(RET, 48'h504, 1'b1);
    total++; if (bus.pc !== 48'h604) $display("FAIL coro_ret: got %h expected 604", bus.pc); else passed++;
    go(RET, 48'h604, 1'b0);
    total++; if (bus.pc !== 48'h608) $display("FAIL coro_empty: got %h expected 608", bus.pc); else passed++;
  endtask

  task automatic test_branch;
    jump(48'h80); go(BEQ, 48'h80, 1'b0);
    total++; if (bus.pc !== 48'h84) $display("FAIL br_reset: got %h expected 84", bus.pc); else passed++;
    train(48'h80, 1'b1, 2); jump(48'h80); go(BEQ, 48'h80, 1'b1);
    total++; if (bus.pc !== 48'hA0) $display("FAIL br_taken: got %h expected a0", bus.pc); else passed++;
    train(48'h80, 1'b0, 2); jump(48'h80); go(BEQ, 48'h80, 1'b0);
    total++; if (bus.pc !== 48'h84) $display("FAIL br_nt: got %h expected 84", bus.pc); else passed++;
    train(48'h80, 1'b1, 3); jump(48'h80); go(BEQ, 48'h80, 1'b1);
    total++; if (bus.pc !== 48'hA0) $display("FAIL br_sat3: got %h expected a0", bus.pc); else passed++;
    train(48'h80, 1'b0, 1); jump(48'h80); go(BEQ, 48'h80, 1'b1);
    total++; if (bus.pc !== 48'hA0) $display("FAIL br_sat3_dec: got %h expected a0", bus.pc); else passed++;
    train(48'h80, 1'b0, 3); train(48'h80, 1'b1, 1); jump(48'h80); go(BEQ, 48'h80, 1'b0);
    total++; if (bus.pc !== 48'h84) $display("FAIL br_sat0: got %h expected 84", bus.pc); else passed++;
    // counter is 1: same-cycle update must not affect this lookup but must land
    jump(48'h80);
    bus.bht_update = 1'b1; bus.bht_update_pc = 48'h80; bus.bht_update_taken = 1'b1;
    go(BEQ, 48'h80, 1'b0);
    bus.bht_update = 1'b0;
    total++; if (bus.pc !== 48'h84) $display("FAIL br_same_lookup: got %h expected 84", bus.pc); else passed++;
    jump(48'h80); go(BEQ, 48'h80, 1'b1);
    total++; if (bus.pc !== 48'hA0) $display("FAIL br_same_update: got %h expected a0", bus.pc); else passed++;
  endtask

  task automatic test_stall;
    jump(48'h200); go(NOP, 48'h200, 1'b0);
    bus.id_stall = 1'b1; bus.i_ready = 1'b1; bus.instr = JAL1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({bus.pc, bus.if_pc, bus.if_instr, bus.if_valid} !== {48'h204, 48'h200, NOP, 1'b1})
        $display("FAIL stall%0d: got pc=%h if_pc=%h ins=%h v=%b expected 204/200/%h/1", i, bus.pc, bus.if_pc, bus.if_instr, bus.if_valid, NOP);
      else passed++;
    end
    bus.id_stall = 1'b0; bus.i_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if ({bus.pc, bus.if_valid} !== {48'h204, 1'b0})
        $display("FAIL idle%0d: got pc=%h v=%b expected 204/0", i, bus.pc, bus.if_valid);
      else passed++;
    end
  endtask

  task automatic test_redirect;
    jump(48'h300); go(JAL1, 48'h300, 1'b1);
    bus.redirect = 1'b1; bus.redirect_pc = 48'h1000; bus.id_stall = 1'b1; bus.i_ready = 1'b1; bus.instr = RET;
    @(posedge clk); #1;
    bus.redirect = 1'b0; bus.id_stall = 1'b0; bus.i_ready = 1'b0;
    total++; if (bus.pc !== 48'h1000) $display("FAIL redir_pc2: got %h expected 1000", bus.pc); else passed++;
    total++; if ({bus.if_valid, bus.if_pred_taken} !== 2'b00) $display("FAIL redir_if: got v=%b tk=%b expected 0/0", bus.if_valid, bus.if_pred_taken); else passed++;
    go(RET, 48'h1000, 1'b1);
    total++; if (bus.pc !== 48'h304) $display("FAIL redir_ras: got %h expected 304", bus.pc); else passed++;
    go(RET, 48'h304, 1'b0);
    total++; if (bus.pc !== 48'h308) $display("FAIL redir_ras_empty: got %h expected 308", bus.pc); else passed++;
  endtask

  task automatic test_ras_overflow;
    logic [47:0] cur, exp_pc;
    jump(48'h2000);
    for (int k = 0; k < 9; k++) go(JAL1, 48'h2000 + 48'(k*256), 1'b1);
    total++; if (bus.pc !== 48'h2900) $display("FAIL ovf_calls: got %h expected 2900", bus.pc); else passed++;
    cur = 48'h2900;
    for (int j = 0; j < 8; j++) begin
      exp_pc = 48'h2004 + 48'((8-j)*256);
      go(RET, cur, 1'b1);
      total++; if (bus.pc !== exp_pc) $display("FAIL ovf_ret%0d: got %h expected %h", j, bus.pc, exp_pc); else passed++;
      cur = exp_pc;
    end
    go(RET, cur, 1'b0);
    total++; if (bus.pc !== cur + 48'd4) $display("FAIL ovf_ret8: got %h expected %h", bus.pc, cur + 48'd4); else passed++;
  endtask

  task automatic test_mid_reset;
    jump(48'h3000); go(JAL1, 48'h3000, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    total++; if ({bus.pc, bus.if_valid} !== {48'h0, 1'b0}) $display("FAIL async_rst: got pc=%h v=%b expected 0/0", bus.pc, bus.if_valid); else passed++;
    #1 n_reset = 1'b1;
    go(RET, 48'h0, 1'b0);
    total++; if (bus.pc !== 48'h4) $display("FAIL rst_ras: got %h expected 4", bus.pc); else passed++;
    jump(48'h80); go(BEQ, 48'h80, 1'b0);
    total++; if (bus.pc !== 48'h84) $display("FAIL rst_bht: got %h expected 84", bus.pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal_ret();
    test_branch();
    test_stall();
    test_redirect();
    test_ras_overflow();
    test_mid_reset();
    repeat (2) @(posedge clk);
    #2;
    total++; if (sbq.size() != 0) $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the RV64IMFD core; owns the 48-bit PC driven to instruction memory.
- Captures the returned instruction and hands it to decode through a one-entry fetch register.
- Predicts next PC the same cycle using a bimodal BHT for conditional branches, direct-target computation for JAL, and a return address stack (RAS) for returns.
- Execute-stage redirects and BHT training come back from downstream.

Parameters:
bht_size, 256, number of 2-bit saturating counters; power of two.
ras_size, 8, RAS depth in entries; power of two.
reset_pc, 48'h0, PC loaded on reset.

Ports:
clk  input  1  clock.
n_reset  input  1  asynchronous active-low reset.
instr  input  32  instruction word at pc, valid when i_ready=1.
i_ready  input  1  instruction memory has returned instr for the current pc.
pc  output  48  fetch address to instruction memory.
if_instr  output  32  fetched instruction to decode.
if_pc  output  48  address of if_instr.
if_pred_taken  output  1  fetch redirected away from if_pc+4.
if_valid  output  1  if_* hold a valid instruction.
id_stall  input  1  decode cannot accept; hold fetch register.
redirect  input  1  mispredict or exception; restart at redirect_pc.
redirect_pc  input  48  restart address.
bht_update  input  1  train BHT this cycle.
bht_update_pc  input  48  PC of the resolved branch.
bht_update_taken  input  1  resolved direction.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low.
- Reset values: pc=reset_pc; if_instr=0; if_pc=0; if_pred_taken=0; if_valid=0; all BHT counters=2'b01 (weakly not-taken); RAS empty (count 0, top pointer 0).
- Reset asserted mid-operation discards all state immediately.

Fetch accept:
- Accept occurs when i_ready=1, id_stall=0 and redirect=0.
- On accept, at the next edge: if_instr<=instr, if_pc<=pc, if_valid<=1, if_pred_taken<=predicted, pc<=next_pc.

Prediction (combinational from instr and pc, zero-bubble):
- Arithmetic: immediates are sign-extended to 48 bits; all additions wrap modulo 2^48.
- BHT index: pc[log2(bht_size)+1:2].
- opcode 1100011 (branch): taken if counter>=2, target pc+imm_B; otherwise pc+4.
- opcode 1101111 (JAL): always taken, target pc+imm_J. If rd is x1 or x5, push pc+4.
- opcode 1100111 (JALR):
  - rs1 in {x1,x5}, rd=x0, RAS non-empty: pop, next_pc=popped value, taken.
  - Same encoding with RAS empty: next_pc=pc+4, not taken, no pop.
  - rd in {x1,x5} and rs1 in {x1,x5}: pop then push pc+4 in the same cycle; count unchanged.
  - Any other JALR: pc+4, not taken; push pc+4 if rd in {x1,x5}.
- Any other opcode: pc+4.

RAS:
- Circular buffer.
- Push when full overwrites the oldest entry; count saturates at ras_size and the pointer wraps.
- Updated only on accepted fetches.

Hold conditions:
- i_ready=0, no stall, no redirect: pc holds; if_valid<=0.
- id_stall=1, no redirect: pc and all if_* hold; instr is ignored.

Redirect (highest priority, overrides stall and i_ready):
- Next edge: pc<=redirect_pc, if_valid<=0, if_pred_taken<=0.
- No RAS or BHT change from the current instr; no RAS repair.

BHT training:
- Independent of fetch.
- When bht_update=1, the counter at bht_update_pc[log2(bht_size)+1:2] increments on taken and decrements on not-taken, saturating at 3 and 0.
- Same-cycle lookup and update of the same index: the lookup sees the old value, and the update lands.

Test Plan:
- Reset → pc=0, if_valid=0. Four NOPs (32'h00000013) with i_ready=1 → pc steps 4,8,12,16; if_pc 0,4,8,12; if_valid=1.
- JAL x1,+0x100 at pc 0x40 → pc=0x140, if_pred_taken=1, RAS top=0x44. Then JALR x0,0(x1) (32'h00008067) at 0x140 → pc=0x44, RAS empty.
- BEQ +0x20 at 0x80, counter reset → pc=0x84. Apply two bht_update taken for 0x80, refetch 0x80 → pc=0xA0. Two not-taken updates → pc=0x84 again. Three further taken updates hold the counter at 3.
- id_stall=1 for 3 cycles with i_ready=1 → pc and if_* constant. i_ready=0 for 2 cycles → pc constant, if_valid=0.
- redirect=1, redirect_pc=0x1000, together with id_stall=1 and i_ready=1 → next pc=0x1000, if_valid=0, RAS count unchanged.
- Nine JAL x1 calls with ras_size=8 → count=8. Nine returns: first eight return the addresses of calls 9 down to 2; the ninth falls through to pc+4.
